key_event_arbiter: RTL and testbench
====================================

// Module: key_event_arbiter
// PURPOSE
//   Collects one-cycle press pulses from NUM_KEYS debounced-key filters and serialises them into
//   a single key-ID event stream with a valid/ready handshake toward the menu/display control logic.
//   Each key holds one pending event; keys are granted round-robin. Events lost to re-press are
//   counted and flagged.
// PARAMETERS
//   NUM_KEYS  4  number of key inputs (2..16)
//   ID_W      2  width of evt_id; must satisfy 2**ID_W >= NUM_KEYS
//   DROP_W    8  width of the saturating drop counter
// PORTS
//   sys_clk      in   1         system clock, 50 MHz
//   sys_rst_n    in   1         reset, asynchronous, active-high (1 = reset), despite the _n suffix
//   key_flag     in   NUM_KEYS  per-key one-cycle press pulse from a debounce filter
//   evt_ready    in   1         consumer accepts evt_id on the cycle evt_valid && evt_ready
//   clr_status   in   1         synchronous clear of overflow and drop_cnt
//   evt_valid    out  1         evt_id holds an unconsumed event
//   evt_id       out  ID_W      index of the pressed key
//   pending      out  NUM_KEYS  per-key pending-event bits (status)
//   overflow     out  1         sticky: at least one press dropped since last clear
//   drop_cnt     out  DROP_W    number of dropped presses, saturates at all-ones
// BEHAVIOUR
//   Reset (sys_rst_n=1, async): evt_valid=0, evt_id=0, pending=0, overflow=0, drop_cnt=0, rr_ptr=0.
//   Pending bits, per key i, evaluated every cycle:
//   - set when key_flag[i]=1.
//   - cleared when key i is granted, unless key_flag[i]=1 in the same cycle; then it stays set.
//     This is a new event, not a drop.
//   - Drop: key_flag[i]=1 while pending[i]=1 and i is not granted this cycle.
//     pending stays 1, overflow<=1, drop_cnt<=drop_cnt+1 (saturating).
//   - Several keys dropping in one cycle add 1 per key, still saturating.
//   Output stage (two states, EMPTY when evt_valid=0, FULL when evt_valid=1):
//   - load_en = !evt_valid || evt_ready.
//   - On load_en with any pending bit set: grant g = first set pending index scanning
//     rr_ptr, rr_ptr+1, ... with wrap from NUM_KEYS-1 to 0.
//     Then evt_valid<=1, evt_id<=g, pending[g] cleared, rr_ptr<=(g==NUM_KEYS-1)?0:g+1.
//   - On load_en with no pending: evt_valid<=0 and evt_id holds its value.
//   - With evt_valid=1 and evt_ready=0: evt_id and evt_valid hold and no grant occurs.
//   - Back-to-back: with evt_ready held high and pending set, one event per cycle.
//   - rr_ptr changes only on a grant.
//   Latency:
//   - key_flag at edge t -> pending at t+1 -> evt_valid at t+2 at the earliest (output EMPTY).
//   - No combinational path from key_flag or evt_ready to any output.
//   clr_status: overflow<=0 and drop_cnt<=0.
//   - A drop in the same cycle wins: overflow<=1, drop_cnt<=1.
//   Reset mid-operation: all pending events and any held event are discarded.
//   - No event is emitted after reset release until a new key_flag pulse.
//   key_flag bits for which no filter is instantiated are tied 0 by the integrator. No internal masking.
// STRUCTURE
//   Shared include key_defs.vh:
//   - `define KEY_NUM and `define KEY_ID_W, used by the top level and the filter array.
//   - `define KEY_DROP_W 8.
//   Sub-module rr_pick #(N, ID_W): purely combinational.
//   - inputs req[N-1:0], ptr[ID_W-1:0]; outputs any, idx[ID_W-1:0]; scans from ptr with wraparound.
//   - Reused later for the LED/segment-refresh scheduler.
//   The top level holds the pending register, the output register, rr_ptr and the status counters.
// TESTING
//   1 Reset, then key_flag=4'b0100 for 1 cycle, evt_ready=1 -> evt_valid high 2 cycles later
//     for 1 cycle, evt_id=2, pending=0.
//   2 key_flag=4'b1111 in one cycle, evt_ready=1, rr_ptr=0 -> evt_id 0,1,2,3 on 4 consecutive
//     cycles. Then flag 4'b0011 -> order 0,1 (rr_ptr wrapped to 0).
//   3 Consumer stall: evt_ready=0 for 10 cycles with key 1 pending -> evt_valid=1 and evt_id=1
//     stable throughout. A second key_flag[1] in the stall -> overflow=1, drop_cnt=1.
//   4 Drop saturation: DROP_W=2, stall output, pulse key_flag[3] 5 times while pending[3]=1
//     -> drop_cnt=3 (saturated), overflow=1. clr_status -> both 0.
//     clr_status coincident with a drop -> drop_cnt=1, overflow=1.
//   5 Grant/re-press collision: key_flag[0] in the cycle key 0 is granted -> no drop,
//     pending[0]=1 next cycle, second event with evt_id=0 follows.
//   6 Assert sys_rst_n mid-stream with pending=4'b1010 and evt_valid=1 -> all outputs 0
//     asynchronously. After release and 20 idle cycles, evt_valid stays 0.

Source files
------------

// File: rtl/key_event_arbiter_pkg.sv
// key_event_arbiter_pkg
//   Shared key-count/width constants for the key event path (top level and
//   the debounce filter array) and the output-stage state encoding.
//   No ports.
package key_event_arbiter_pkg;

    localparam int KEY_NUM    = 4;   // number of debounced keys
    localparam int KEY_ID_W   = 2;   // width of a key index, 2**KEY_ID_W >= KEY_NUM
    localparam int KEY_DROP_W = 8;   // width of the saturating drop counter

    // Output register state: EMPTY <=> evt_valid=0, FULL <=> evt_valid=1.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/key_event_arbiter_rr_pick.sv
// rr_pick
//   Purely combinational round-robin picker: returns the first set request
//   index found scanning ptr, ptr+1, ... with wraparound from N-1 to 0.
//   Ports:
//     req [N-1:0]     request vector
//     ptr [ID_W-1:0]  scan start index (expected < N)
//     any             at least one request set
//     idx [ID_W-1:0]  chosen index (0 when any=0)
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            any,
    output logic [ID_W-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             s;

    always_comb begin
        any = |req;
        idx = '0;
        s   = 0;
        // Rotate so bit 0 of rot is request[ptr]; the lowest set bit of rot
        // is then the first request in round-robin order.
        dbl = {req, req} >> ptr;
        rot = dbl[N-1:0];
        // Descending scan: the last hit written is the smallest offset.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                s = int'(ptr) + k;
                if (s >= N) begin
                    s = s - N;
                end
                idx = ID_W'(s);
            end
        end
    end

endmodule

// File: rtl/key_event_arbiter.sv
// key_event_arbiter
//   Serialises one-cycle key press pulses into a key-ID event stream with a
//   valid/ready handshake. One pending event per key, round-robin grant,
//   re-presses of a still-pending key are counted as drops.
//   Ports:
//     sys_clk               system clock
//     sys_rst_n             asynchronous reset, ACTIVE-HIGH despite the name
//     key_flag [NUM_KEYS]   per-key press pulse
//     evt_ready             consumer accepts when evt_valid && evt_ready
//     clr_status            synchronous clear of overflow/drop_cnt
//     evt_valid, evt_id     event output register
//     pending [NUM_KEYS]    per-key pending bits
//     overflow              sticky drop flag
//     drop_cnt [DROP_W]     saturating drop count
module key_event_arbiter
    import key_event_arbiter_pkg::*;
#(
    parameter int NUM_KEYS = KEY_NUM,
    parameter int ID_W     = KEY_ID_W,
    parameter int DROP_W   = KEY_DROP_W
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [NUM_KEYS-1:0] key_flag,
    input  logic                evt_ready,
    input  logic                clr_status,
    output logic                evt_valid,
    output logic [ID_W-1:0]     evt_id,
    output logic [NUM_KEYS-1:0] pending,
    output logic                overflow,
    output logic [DROP_W-1:0]   drop_cnt
);

    localparam int CNT_W = $clog2(NUM_KEYS + 1);
    localparam int SUM_W = DROP_W + CNT_W;

    out_state_e          state_q, state_d;
    logic [ID_W-1:0]     evt_id_q, evt_id_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_KEYS-1:0] pending_q, pending_d;
    logic                overflow_q, overflow_d;
    logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic                load_en;
    logic                pick_any;
    logic [ID_W-1:0]     pick_idx;
    logic [NUM_KEYS-1:0] grant_vec;
    logic [NUM_KEYS-1:0] drop_vec;
    logic [CNT_W-1:0]    drop_num;
    logic [DROP_W-1:0]   drop_base;
    logic [SUM_W-1:0]    drop_sum;

    // The output register may take a new event when empty or being consumed.
    assign load_en = (state_q == ST_EMPTY) || evt_ready;

    rr_pick #(
        .N    (NUM_KEYS),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req (pending_q),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            assign grant_vec[gi] = load_en && pick_any && (pick_idx == ID_W'(gi));
            // A press in the grant cycle re-arms the bit as a fresh event.
            assign pending_d[gi] = key_flag[gi] | (pending_q[gi] & ~grant_vec[gi]);
            assign drop_vec[gi]  = key_flag[gi] & pending_q[gi] & ~grant_vec[gi];
        end
    endgenerate

    // Output stage next state.
    always_comb begin
        state_d  = state_q;
        evt_id_d = evt_id_q;
        rr_ptr_d = rr_ptr_q;
        if (load_en) begin
            if (pick_any) begin
                state_d  = ST_FULL;
                evt_id_d = pick_idx;
                rr_ptr_d = (pick_idx == ID_W'(NUM_KEYS - 1)) ? '0 : pick_idx + 1'b1;
            end else begin
                state_d = ST_EMPTY;
            end
        end
    end

    // Status: clear first, then add this cycle's drops so a coincident drop wins.
    always_comb begin
        drop_num = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (drop_vec[k]) begin
                drop_num = drop_num + 1'b1;
            end
        end
        drop_base = clr_status ? '0 : drop_cnt_q;
        drop_sum  = SUM_W'(drop_base) + SUM_W'(drop_num);
        if (drop_sum > SUM_W'({DROP_W{1'b1}})) begin
            drop_cnt_d = '1;
        end else begin
            drop_cnt_d = drop_sum[DROP_W-1:0];
        end
        overflow_d = (|drop_vec) | (overflow_q & ~clr_status);
    end

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            state_q    <= ST_EMPTY;
            evt_id_q   <= '0;
            rr_ptr_q   <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            evt_id_q   <= evt_id_d;
            rr_ptr_q   <= rr_ptr_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign evt_valid = (state_q == ST_FULL);
    assign evt_id    = evt_id_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// tb_key_event_arbiter
//   Directed test of key_event_arbiter (4 keys, 2-bit drop counter).
//   Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_key_event_arbiter;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [3:0] key_flag;
    logic       evt_ready;
    logic       clr_status;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic [3:0] pending;
    logic       overflow;
    logic [1:0] drop_cnt;

    int n_checks;
    int n_errors;

    key_event_arbiter #(
        .NUM_KEYS (4),
        .ID_W     (2),
        .DROP_W   (2)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_flag   (key_flag),
        .evt_ready  (evt_ready),
        .clr_status (clr_status),
        .evt_valid  (evt_valid),
        .evt_id     (evt_id),
        .pending    (pending),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Valid, id, pending in one call.
    task automatic chk_out(input string tag, input logic v, input logic [1:0] id,
                           input logic [3:0] pend);
        chk({tag, ".valid"}, 32'(evt_valid), 32'(v));
        if (v) chk({tag, ".id"}, 32'(evt_id), 32'(id));
        chk({tag, ".pend"}, 32'(pending), 32'(pend));
    endtask

    task automatic do_reset();
        sys_rst_n  = 1'b1;
        key_flag   = '0;
        clr_status = 1'b0;
        tick();
        tick();
        sys_rst_n = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        sys_rst_n  = 1'b1;
        key_flag   = '0;
        evt_ready  = 1'b1;
        clr_status = 1'b0;
        #1;
        chk("rst.valid", 32'(evt_valid), 0);
        chk("rst.id", 32'(evt_id), 0);
        chk("rst.pend", 32'(pending), 0);
        chk("rst.ovf", 32'(overflow), 0);
        chk("rst.drop", 32'(drop_cnt), 0);

        // 1: single press, two-cycle latency
        do_reset();
        key_flag = 4'b0100; tick();
        key_flag = 4'b0000;
        chk_out("t1.c1", 1'b0, 2'd0, 4'b0100);
        tick(); chk_out("t1.c2", 1'b1, 2'd2, 4'b0000);
        tick(); chk_out("t1.c3", 1'b0, 2'd0, 4'b0000);
        chk("t1.idhold", 32'(evt_id), 2);

        // 2: all four keys, then wrap
        do_reset();
        key_flag = 4'b1111; tick();
        key_flag = 4'b0000;
        tick(); chk_out("t2.e0", 1'b1, 2'd0, 4'b1110);
        tick(); chk_out("t2.e1", 1'b1, 2'd1, 4'b1100);
        tick(); chk_out("t2.e2", 1'b1, 2'd2, 4'b1000);
        tick(); chk_out("t2.e3", 1'b1, 2'd3, 4'b0000);
        tick(); chk_out("t2.idle", 1'b0, 2'd0, 4'b0000);
        key_flag = 4'b0011; tick();
        key_flag = 4'b0000;
        tick(); chk_out("t2.w0", 1'b1, 2'd0, 4'b0010);
        tick(); chk_out("t2.w1", 1'b1, 2'd1, 4'b0000);
        tick(); chk_out("t2.widle", 1'b0, 2'd0, 4'b0000);

        // 3: consumer stall with a drop on key 1
        do_reset();
        evt_ready = 1'b0;
        key_flag = 4'b0010; tick();
        key_flag = 4'b0000; tick();
        chk_out("t3.load", 1'b1, 2'd1, 4'b0000);
        key_flag = 4'b0010; tick();
        key_flag = 4'b0000;
        chk_out("t3.repend", 1'b1, 2'd1, 4'b0010);
        for (int i = 0; i < 10; i++) begin
            key_flag = (i == 4) ? 4'b0010 : 4'b0000;
            tick();
            chk(i == 4 ? "t3.stall.valid.drop" : "t3.stall.valid", 32'(evt_valid), 1);
            chk("t3.stall.id", 32'(evt_id), 1);
        end
        key_flag = 4'b0000;
        chk("t3.ovf", 32'(overflow), 1);
        chk("t3.drop", 32'(drop_cnt), 1);
        chk("t3.pend", 32'(pending), 4'b0010);
        evt_ready = 1'b1;
        tick(); chk_out("t3.rel", 1'b1, 2'd1, 4'b0000);
        tick(); chk_out("t3.empty", 1'b0, 2'd0, 4'b0000);

        // 4: drop saturation and clear
        do_reset();
        evt_ready = 1'b0;
        key_flag = 4'b1000; tick();
        key_flag = 4'b0000; tick();
        chk_out("t4.load", 1'b1, 2'd3, 4'b0000);
        key_flag = 4'b1000; tick();
        chk("t4.nodrop", 32'(drop_cnt), 0);
        for (int i = 0; i < 5; i++) tick();
        key_flag = 4'b0000;
        chk("t4.sat", 32'(drop_cnt), 3);
        chk("t4.ovf", 32'(overflow), 1);
        clr_status = 1'b1; tick();
        clr_status = 1'b0;
        chk("t4.clr.drop", 32'(drop_cnt), 0);
        chk("t4.clr.ovf", 32'(overflow), 0);
        clr_status = 1'b1; key_flag = 4'b1000; tick();
        clr_status = 1'b0; key_flag = 4'b0000;
        chk("t4.clrdrop.drop", 32'(drop_cnt), 1);
        chk("t4.clrdrop.ovf", 32'(overflow), 1);
        evt_ready = 1'b1;

        // 5: re-press in the grant cycle is a new event
        do_reset();
        key_flag = 4'b0001; tick();
        key_flag = 4'b0001; tick();
        key_flag = 4'b0000;
        chk_out("t5.g1", 1'b1, 2'd0, 4'b0001);
        chk("t5.nodrop", 32'(drop_cnt), 0);
        chk("t5.noovf", 32'(overflow), 0);
        tick(); chk_out("t5.g2", 1'b1, 2'd0, 4'b0000);
        tick(); chk_out("t5.empty", 1'b0, 2'd0, 4'b0000);

        // 6: asynchronous reset mid-stream
        do_reset();
        evt_ready = 1'b0;
        key_flag = 4'b0001; tick();
        key_flag = 4'b0000; tick();
        key_flag = 4'b1010; tick();
        key_flag = 4'b0000;
        chk_out("t6.pre", 1'b1, 2'd0, 4'b1010);
        #2 sys_rst_n = 1'b1;
        #1;
        chk("t6.async.valid", 32'(evt_valid), 0);
        chk("t6.async.id", 32'(evt_id), 0);
        chk("t6.async.pend", 32'(pending), 0);
        tick();
        sys_rst_n = 1'b0;
        evt_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t6.idle.valid", 32'(evt_valid), 0);
        end
        chk("t6.idle.pend", 32'(pending), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
